fpu_share_arb: RTL

Round-robin arbiter and response router that shares one `fpnew_top_dummy` FPU instance between `NUM_REQ` requesters, such as two integer pipelines or a core plus an accelerator. It sits between the requesters' FP issue ports and the FPU input handshake. It tracks the owner of every in-flight operation in an ID FIFO, and it delivers each result to a per-requester response buffer. Per-requester credits guarantee that the FPU's one-cycle, non-stallable `out_valid` pulse always has a free slot to land in.

---
 rtl/fpu_share_arb_pkg.sv | 47 ++++
 rtl/fpu_share_arb_rr_pick.sv | 35 +++
 rtl/fpu_share_arb.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fpu_share_arb_pkg.sv
// Shared types for the FPU sharing arbiter: FPU request/response structs and FP enums.
package fpu_share_arb_pkg;

   localparam int unsigned MAX_FPU_INFLIGHT = 8;
   localparam int unsigned FPU_W            = 64;
   localparam int unsigned TAG_W            = 8;

   typedef logic [TAG_W-1:0] tag_t;

   typedef enum logic [2:0] {RNE, RTZ, RDN, RUP, RMM, DYN = 3'b111} roundmode_e;

   typedef enum logic [3:0] {
      FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
      CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
   } operation_e;

   typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

   typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;

   typedef struct packed {
      logic NV;
      logic DZ;
      logic OF;
      logic UF;
      logic NX;
   } status_t;

   typedef struct packed {
      logic [2:0][FPU_W-1:0] operands;
      roundmode_e            rnd_mode;
      operation_e            op;
      logic                  op_mod;
      fp_format_e            src_fmt;
      fp_format_e            dst_fmt;
      int_format_e           int_fmt;
      logic                  vectorial;
      tag_t                  tag;
   } fpu_req_t;

   typedef struct packed {
      logic [FPU_W-1:0] result;
      status_t          status;
      tag_t             tag;
   } fpu_rsp_t;

endpackage

// File: rtl/fpu_share_arb_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping.
module fpu_share_arb_rr_pick #(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned IdW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IdW-1:0]     ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IdW-1:0]     id
);

   logic found;

   always_comb begin
      grant = '0;
      id    = '0;
      found = 1'b0;
      // upper segment [ptr, NUM_REQ) first, then the wrapped segment [0, ptr)
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && eligible[i] && (IdW'(i) >= ptr)) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            id       = IdW'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && eligible[i] && (IdW'(i) < ptr)) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            id       = IdW'(i);
         end
      end
   end

endmodule

// File: rtl/fpu_share_arb.sv
// Shares one FPU between NUM_REQ requesters with credit-backed response buffers.
// Optional macro FPU_SHARE_ARB_PERF_EN adds per-requester grant/stall counters.
module fpu_share_arb import fpu_share_arb_pkg::*; #(
   parameter  int unsigned NUM_REQ = 2,
   parameter  int unsigned CREDITS = 2,
   parameter  int unsigned WIDTH   = 64,
   parameter  type         TagType = tag_t,
   localparam int unsigned IdW     = $clog2(NUM_REQ)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  fpu_req_t [NUM_REQ-1:0]     req_i,
   output logic [NUM_REQ-1:0]         rsp_valid_o,
   input  logic [NUM_REQ-1:0]         rsp_ready_i,
   output fpu_rsp_t [NUM_REQ-1:0]     rsp_o,
   output logic                       fpu_in_valid_o,
   input  logic                       fpu_in_ready_i,
   output fpu_req_t                   fpu_req_o,
   input  logic                       fpu_out_valid_i,
   output logic                       fpu_out_ready_o,
   input  logic [WIDTH-1:0]           fpu_result_i,
   input  status_t                    fpu_status_i,
   output logic                       fpu_flush_o,
   output logic                       busy_o,
   output logic                       proto_err_o
`ifdef FPU_SHARE_ARB_PERF_EN
  ,output logic [NUM_REQ-1:0][31:0]   perf_grant_cnt_o,
   output logic [NUM_REQ-1:0][31:0]   perf_stall_cnt_o
`endif
);

   localparam int unsigned DEPTH = NUM_REQ * CREDITS;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned BW    = (CREDITS > 1) ? $clog2(CREDITS) : 1;
   localparam int unsigned CW    = $clog2(CREDITS + 1);
   localparam logic [AW:0] IDQ_ONE = 1;
   localparam logic [BW:0] RB_ONE  = 1;
   localparam logic [CW-1:0] CR_ONE = 1;

   if ((NUM_REQ < 2) || (DEPTH > MAX_FPU_INFLIGHT) || (WIDTH != FPU_W)) begin : g_bad_cfg
      $error("fpu_share_arb: illegal NUM_REQ/CREDITS/WIDTH combination");
   end

   // Circular-buffer pointers carry one extra wrap bit so equal index means empty or full.
   function automatic logic [AW:0] idq_inc(input logic [AW:0] p);
      if (p[AW-1:0] == AW'(DEPTH - 1)) return {~p[AW], {AW{1'b0}}};
      return p + IDQ_ONE;
   endfunction

   function automatic logic [BW:0] rb_inc(input logic [BW:0] p);
      if (p[BW-1:0] == BW'(CREDITS - 1)) return {~p[BW], {BW{1'b0}}};
      return p + RB_ONE;
   endfunction

   logic [NUM_REQ-1:0] eligible, grant, dec, pop;
   logic [IdW-1:0]     grant_id, rr_ptr, head_id;
   logic [CW-1:0]      credit [NUM_REQ];
   logic               accept, idq_empty, ret;

   logic [IdW-1:0]     idq_id  [DEPTH];
   TagType             idq_tag [DEPTH];
   logic [AW:0]        idq_wr, idq_rd;
   TagType             head_tag;

   fpu_rsp_t           rsp_mem [NUM_REQ][CREDITS];
   logic [BW:0]        rb_wr [NUM_REQ];
   logic [BW:0]        rb_rd [NUM_REQ];

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid_i[i] && (credit[i] != '0) && !flush_i;
      end
   end

   fpu_share_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .eligible (eligible),
      .ptr      (rr_ptr),
      .grant    (grant),
      .id       (grant_id)
   );

   assign fpu_in_valid_o  = |eligible;
   assign req_ready_o     = grant & {NUM_REQ{fpu_in_ready_i}};
   assign accept          = fpu_in_valid_o && fpu_in_ready_i;
   assign dec             = grant & {NUM_REQ{accept}};
   assign fpu_out_ready_o = 1'b1;
   assign fpu_flush_o     = flush_i;

   always_comb begin
      fpu_req_o     = req_i[grant_id];
      fpu_req_o.tag = tag_t'(grant_id);
   end

   assign idq_empty = (idq_wr == idq_rd);
   assign head_id   = idq_id[idq_rd[AW-1:0]];
   assign head_tag  = idq_tag[idq_rd[AW-1:0]];
   assign ret       = fpu_out_valid_i && !flush_i && !idq_empty;

   always_comb begin
      rsp_valid_o = '0;
      rsp_o       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid_o[i] = (rb_wr[i] != rb_rd[i]);
         if (rsp_valid_o[i]) rsp_o[i] = rsp_mem[i][rb_rd[i][BW-1:0]];
      end
   end

   assign pop    = rsp_valid_o & rsp_ready_i;
   assign busy_o = !idq_empty || (|rsp_valid_o);

   // Control state: pointers, credits, round-robin pointer, sticky error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr      <= '0;
         idq_wr      <= '0;
         idq_rd      <= '0;
         proto_err_o <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            credit[i] <= CW'(CREDITS);
            rb_wr[i]  <= '0;
            rb_rd[i]  <= '0;
         end
      end else if (flush_i) begin
         rr_ptr <= '0;
         idq_wr <= '0;
         idq_rd <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            credit[i] <= CW'(CREDITS);
            rb_wr[i]  <= '0;
            rb_rd[i]  <= '0;
         end
      end else begin
         if (accept) begin
            idq_wr <= idq_inc(idq_wr);
            rr_ptr <= (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + IdW'(1);
         end
         if (fpu_out_valid_i && idq_empty) proto_err_o <= 1'b1;
         if (ret) idq_rd <= idq_inc(idq_rd);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (ret && (head_id == IdW'(i))) rb_wr[i] <= rb_inc(rb_wr[i]);
            if (pop[i]) rb_rd[i] <= rb_inc(rb_rd[i]);
            if (dec[i] && !pop[i])      credit[i] <= credit[i] - CR_ONE;
            else if (pop[i] && !dec[i]) credit[i] <= credit[i] + CR_ONE;
         end
      end
   end

   // Data storage: written only on accepted transfers and valid returns.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         idq_id[idq_wr[AW-1:0]]  <= grant_id;
         idq_tag[idq_wr[AW-1:0]] <= TagType'(req_i[grant_id].tag);
      end
      if (ret) begin
         rsp_mem[head_id][rb_wr[head_id][BW-1:0]] <= '{result: fpu_result_i,
                                                       status: fpu_status_i,
                                                       tag:    tag_t'(head_tag)};
      end
   end

`ifdef FPU_SHARE_ARB_PERF_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_grant_cnt_o <= '0;
         perf_stall_cnt_o <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (dec[i]) perf_grant_cnt_o[i] <= perf_grant_cnt_o[i] + 32'd1;
            if (req_valid_i[i] && !req_ready_o[i]) perf_stall_cnt_o[i] <= perf_stall_cnt_o[i] + 32'd1;
         end
      end
   end
`endif

endmodule
